// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: passes non-memory bundles straight through,
// runs one bus transfer at a time for aligned loads/stores, and flags misaligned
// accesses and bus timeouts through exc_o.
module mem_lsu #(
    parameter int ADDR_W     = 32,
    parameter int REG_AW     = 5,
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] wd_i,
    input  logic [31:0]       wdata_i,
    input  logic              wreg_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              out_valid,
    output logic [REG_AW-1:0] wd_o,
    output logic [31:0]       wdata_o,
    output logic              wreg_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic [1:0]        exc_o
);
    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [REG_AW-1:0] wd;
        logic [31:0]       wdata;
        logic              wreg;
        logic              whilo;
        logic [31:0]       hi;
        logic [31:0]       lo;
    } bundle_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         bwdata_q, bwdata_d;
    logic                ovld_q, ovld_d;
    logic [1:0]          exc_q, exc_d;
    bundle_t             out_q, out_d;
    bundle_t             pend_q, pend_d;
    logic [1:0]          psize_q, psize_d;
    logic                psext_q, psext_d;
    logic                pload_q, pload_d;
    logic [1:0]          plane_q, plane_d;

    logic                is_load, is_store, sext;
    logic [1:0]          size;
    logic                misalign;
    bundle_t             in_b;

    // Lane enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] le;
        case (sz)
            SZ_B:    le = 4'b0001 << a;
            SZ_H:    le = a[1] ? 4'b1100 : 4'b0011;
            default: le = 4'b1111;
        endcase
        calc_be = BIG_ENDIAN ? {le[0], le[1], le[2], le[3]} : le;
    endfunction

    // Sub-word store data is replicated so every candidate lane carries it.
    function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_B:    store_rep = {4{d[7:0]}};
            SZ_H:    store_rep = {2{d[15:0]}};
            default: store_rep = d;
        endcase
    endfunction

    // Pick the addressed lane(s) out of the read word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic sx,
                                                 input logic [1:0] a, input logic [31:0] d);
        logic [1:0]  bl;
        logic        hl;
        logic [7:0]  b;
        logic [15:0] h;
        bl = BIG_ENDIAN ? ~a : a;
        hl = BIG_ENDIAN ? ~a[1] : a[1];
        b  = 8'(d >> {bl, 3'b000});
        h  = 16'(d >> {hl, 4'b0000});
        case (sz)
            SZ_B:    load_extract = {{24{sx & b[7]}}, b};
            SZ_H:    load_extract = {{16{sx & h[15]}}, h};
            default: load_extract = d;
        endcase
    endfunction

    // Decode the incoming operation into direction, size, signedness and alignment.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (mem_op_i)
            4'd1: begin is_load = 1'b1;  size = SZ_B; sext = 1'b1; end
            4'd2: begin is_load = 1'b1;  size = SZ_B; end
            4'd3: begin is_load = 1'b1;  size = SZ_H; sext = 1'b1; end
            4'd4: begin is_load = 1'b1;  size = SZ_H; end
            4'd5: begin is_load = 1'b1;  size = SZ_W; end
            4'd6: begin is_store = 1'b1; size = SZ_B; end
            4'd7: begin is_store = 1'b1; size = SZ_H; end
            4'd8: begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
        misalign = ((size == SZ_H) && mem_addr_i[0]) ||
                   ((size == SZ_W) && (mem_addr_i[1:0] != 2'b00));
        in_b = '{wd: wd_i, wdata: wdata_i, wreg: wreg_i, whilo: whilo_i, hi: hi_i, lo: lo_i};
    end

    // Next-state, bus request and result bundle for the IDLE/WAIT controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        ovld_d   = 1'b0;
        exc_d    = exc_q;
        out_d    = out_q;
        pend_d   = pend_q;
        psize_d  = psize_q;
        psext_d  = psext_q;
        pload_d  = pload_q;
        plane_d  = plane_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!(is_load || is_store)) begin
                        out_d  = in_b;
                        ovld_d = 1'b1;
                        exc_d  = 2'd0;
                    end else if (misalign) begin
                        out_d       = in_b;
                        out_d.wreg  = 1'b0;
                        out_d.whilo = 1'b0;
                        ovld_d      = 1'b1;
                        exc_d       = is_load ? 2'd1 : 2'd2;
                    end else begin
                        state_d  = WAIT;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        be_d     = calc_be(size, mem_addr_i[1:0]);
                        bwdata_d = store_rep(size, mem_sdata_i);
                        pend_d   = in_b;
                        psize_d  = size;
                        psext_d  = sext;
                        pload_d  = is_load;
                        plane_d  = mem_addr_i[1:0];
                    end
                end
            end
            WAIT: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ovld_d  = 1'b1;
                    exc_d   = 2'd0;
                    out_d   = pend_q;
                    if (pload_q)
                        out_d.wdata = load_extract(psize_q, psext_q, plane_q, bus_rdata);
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    ovld_d      = 1'b1;
                    exc_d       = 2'd3;
                    out_d       = pend_q;
                    out_d.wreg  = 1'b0;
                    out_d.whilo = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
            ovld_q   <= 1'b0;
            exc_q    <= '0;
            out_q    <= '0;
            pend_q   <= '0;
            psize_q  <= '0;
            psext_q  <= 1'b0;
            pload_q  <= 1'b0;
            plane_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            ovld_q   <= ovld_d;
            exc_q    <= exc_d;
            out_q    <= out_d;
            pend_q   <= pend_d;
            psize_q  <= psize_d;
            psext_q  <= psext_d;
            pload_q  <= pload_d;
            plane_q  <= plane_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = bwdata_q;
    assign out_valid = ovld_q;
    assign exc_o     = exc_q;
    assign wd_o      = out_q.wd;
    assign wdata_o   = out_q.wdata;
    assign wreg_o    = out_q.wreg;
    assign whilo_o   = out_q.whilo;
    assign hi_o      = out_q.hi;
    assign lo_o      = out_q.lo;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed vector table, randomized transactions against
// a byte-level reference model, and hand-written reset / back-to-back sequences.
`timescale 1ns/1ps
module tb_mem_lsu;
    localparam int ADDR_W  = 32;
    localparam int REG_AW  = 5;
    localparam int TMO     = 4;
    localparam bit BE_MODE = 1'b0;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] wd_i;
    logic [31:0]       wdata_i;
    logic              wreg_i;
    logic              whilo_i;
    logic [31:0]       hi_i;
    logic [31:0]       lo_i;
    logic [3:0]        mem_op_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_sdata_i;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;
    logic              out_valid;
    logic [REG_AW-1:0] wd_o;
    logic [31:0]       wdata_o;
    logic              wreg_o;
    logic              whilo_o;
    logic [31:0]       hi_o;
    logic [31:0]       lo_o;
    logic [1:0]        exc_o;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TMO), .BIG_ENDIAN(BE_MODE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wd_i(wd_i), .wdata_i(wdata_i), .wreg_i(wreg_i), .whilo_i(whilo_i),
        .hi_i(hi_i), .lo_i(lo_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_sdata_i(mem_sdata_i), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .out_valid(out_valid),
        .wd_o(wd_o), .wdata_o(wdata_o), .wreg_o(wreg_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .exc_o(exc_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // ack on the (ack_dly+1)-th wait edge; >= TMO means never
        bit          e_req;
        logic [3:0]  e_be;
        logic [31:0] e_bw;
        logic [31:0] e_res;
        logic [1:0]  e_exc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic int lane_of(input logic [31:0] a);
        return BE_MODE ? 3 - int'(a[1:0]) : int'(a[1:0]);
    endfunction

    // Reference: walk the bytes touched by the access and place/collect each one.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [31:0] rdata, inout vec_t v);
        int     sz;
        int     ln;
        int     vb;
        longint val;
        sz = op_size(op);
        v.op = op; v.addr = addr; v.sdata = sdata; v.wdata = wdata; v.rdata = rdata;
        v.e_req = 1'b0; v.e_be = 4'd0; v.e_bw = 32'd0; v.e_res = wdata; v.e_exc = 2'd0;
        if (sz == 0) return;
        if ((int'(addr[1:0]) % sz) != 0) begin
            v.e_exc = (op <= 4'd5) ? 2'd1 : 2'd2;
            return;
        end
        v.e_req = 1'b1;
        val = 0;
        for (int i = 0; i < sz; i++) begin
            ln = lane_of(addr + 32'(i));
            vb = BE_MODE ? sz - 1 - i : i;
            v.e_be[ln] = 1'b1;
            v.e_bw[8*ln +: 8] = sdata[8*vb +: 8];
            val = val | (longint'(rdata[8*ln +: 8]) << (8 * vb));
        end
        if ((op == 4'd1 || op == 4'd3) && (((val >> (8 * sz - 1)) & 1) == 1))
            val = val - (longint'(1) << (8 * sz));
        if (op <= 4'd5) v.e_res = 32'(val);
        if (v.ack_dly >= TMO) v.e_exc = 2'd3;
    endtask

    // Issue one bundle, serve the bus as the vector says, and check the result pulse.
    task automatic do_txn(input string tag, input vec_t v);
        logic [REG_AW-1:0] e_wd;
        logic              e_wreg, e_whilo;
        logic [31:0]       e_hi, e_lo, mask;
        e_wd = REG_AW'($urandom); e_wreg = 1'($urandom); e_whilo = 1'($urandom);
        e_hi = $urandom; e_lo = $urandom;
        wd_i = e_wd; wreg_i = e_wreg; whilo_i = e_whilo; hi_i = e_hi; lo_i = e_lo;
        mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata; wdata_i = v.wdata;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wd_i = REG_AW'($urandom); wdata_i = $urandom; hi_i = $urandom; lo_i = $urandom;
        mem_op_i = 4'($urandom); mem_addr_i = $urandom; mem_sdata_i = $urandom;
        mask = {{8{v.e_be[3]}}, {8{v.e_be[2]}}, {8{v.e_be[1]}}, {8{v.e_be[0]}}};
        if (v.e_req) begin
            for (int k = 1; k <= TMO; k++) begin
                chk({tag, " bus_req"}, 32'(bus_req), 32'd1);
                chk({tag, " bus_we"}, 32'(bus_we), 32'(v.op >= 4'd6));
                chk({tag, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
                chk({tag, " bus_be"}, 32'(bus_be), 32'(v.e_be));
                if (v.op >= 4'd6) chk({tag, " bus_wdata"}, bus_wdata & mask, v.e_bw & mask);
                chk({tag, " wait out_valid"}, 32'(out_valid), 32'd0);
                chk({tag, " wait in_ready"}, 32'(in_ready), 32'd0);
                bus_ack   = (k == v.ack_dly + 1);
                bus_rdata = (k == v.ack_dly + 1) ? v.rdata : $urandom;
                tick();
                bus_ack = 1'b0;
                if (k == v.ack_dly + 1) break;
            end
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " exc_o"}, 32'(exc_o), 32'(v.e_exc));
        chk({tag, " wreg_o"}, 32'(wreg_o), 32'((v.e_exc == 2'd0) ? e_wreg : 1'b0));
        chk({tag, " whilo_o"}, 32'(whilo_o), 32'((v.e_exc == 2'd0) ? e_whilo : 1'b0));
        chk({tag, " bus_req after"}, 32'(bus_req), 32'd0);
        if (v.e_exc != 2'd3) begin
            chk({tag, " wd_o"}, 32'(wd_o), 32'(e_wd));
            chk({tag, " wdata_o"}, wdata_o, v.e_res);
            chk({tag, " hi_o"}, hi_o, e_hi);
            chk({tag, " lo_o"}, lo_o, e_lo);
        end
        tick();
        chk({tag, " pulse end"}, 32'(out_valid), 32'd0);
    endtask

    vec_t tbl [11];
    vec_t rv;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //               op     addr          sdata         wdata         rdata         dly req be       bw            res           exc
        tbl[0]  = '{4'd1,  32'h0000_1003, 32'h0,        32'h1111_1111, 32'h80FF_1234, 2,  1, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'd0};
        tbl[1]  = '{4'd2,  32'h0000_1003, 32'h0,        32'h1111_1111, 32'h80FF_1234, 2,  1, 4'b1000, 32'h0,        32'h0000_0080, 2'd0};
        tbl[2]  = '{4'd7,  32'h0000_2002, 32'h0000_ABCD, 32'h2222_2222, 32'h0,        1,  1, 4'b1100, 32'hABCD_ABCD, 32'h2222_2222, 2'd0};
        tbl[3]  = '{4'd5,  32'h0000_0006, 32'h0,        32'h3333_3333, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h3333_3333, 2'd1};
        tbl[4]  = '{4'd5,  32'h0000_0040, 32'h0,        32'h5555_5555, 32'h0,        99, 1, 4'b1111, 32'h0,        32'h0,        2'd3};
        tbl[5]  = '{4'd3,  32'h0000_0102, 32'h0,        32'h0,        32'h8001_7FFF, 3,  1, 4'b1100, 32'h0,        32'hFFFF_8001, 2'd0};
        tbl[6]  = '{4'd8,  32'h0000_0301, 32'h1234_5678, 32'h6666_6666, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h6666_6666, 2'd2};
        tbl[7]  = '{4'd4,  32'h0000_0000, 32'h0,        32'h0,        32'h1234_F00D, 0,  1, 4'b0011, 32'h0,        32'h0000_F00D, 2'd0};
        tbl[8]  = '{4'd6,  32'h0000_0005, 32'h0000_00A5, 32'h7777_7777, 32'h0,        0,  1, 4'b0010, 32'hA5A5_A5A5, 32'h7777_7777, 2'd0};
        tbl[9]  = '{4'd12, 32'h0000_0007, 32'h0,        32'h4444_4444, 32'h0,        0,  0, 4'b0000, 32'h0,        32'h4444_4444, 2'd0};
        tbl[10] = '{4'd5,  32'h0000_00FC, 32'h0,        32'h0,        32'hDEAD_BEEF, 0,  1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2'd0};

        rst = 1'b1; in_valid = 1'b0; wd_i = '0; wdata_i = '0; wreg_i = 1'b0; whilo_i = 1'b0;
        hi_i = '0; lo_i = '0; mem_op_i = '0; mem_addr_i = '0; mem_sdata_i = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_we", 32'(bus_we), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_be", 32'(bus_be), 32'd0);
        chk("rst bus_wdata", bus_wdata, 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst exc_o", 32'(exc_o), 32'd0);
        chk("rst bundle", {wd_o, wreg_o, whilo_o} | wdata_o | hi_o | lo_o, 32'd0);

        // Directed vectors
        for (int i = 0; i < 11; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

        // NONE stream, back to back
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; mem_op_i = 4'd0; wd_i = REG_AW'(3 + i); wreg_i = 1'b1;
            tick();
            chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d wd_o", i), 32'(wd_o), 32'(3 + i));
            chk($sformatf("stream%0d bus_req", i), 32'(bus_req), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("stream end out_valid", 32'(out_valid), 32'd0);

        // New bundle accepted in the same cycle as a completion pulse
        in_valid = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h10; wd_i = REG_AW'(9); wreg_i = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("overlap bus_req", 32'(bus_req), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0;
        chk("overlap load out_valid", 32'(out_valid), 32'd1);
        chk("overlap load wdata_o", wdata_o, 32'hCAFE_F00D);
        chk("overlap in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mem_op_i = 4'd0; wd_i = REG_AW'(7); wdata_i = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("overlap none out_valid", 32'(out_valid), 32'd1);
        chk("overlap none wd_o", 32'(wd_o), 32'd7);
        chk("overlap none wdata_o", wdata_o, 32'h77);
        tick();
        chk("overlap end out_valid", 32'(out_valid), 32'd0);

        // Reset while waiting on the bus
        in_valid = 1'b1; mem_op_i = 4'd8; mem_addr_i = 32'h20; mem_sdata_i = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("rstwait bus_req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwait bus_req drop", 32'(bus_req), 32'd0);
        chk("rstwait out_valid", 32'(out_valid), 32'd0);
        chk("rstwait in_ready", 32'(in_ready), 32'd1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("rstwait late ack out_valid", 32'(out_valid), 32'd0);
        chk("rstwait late ack bus_req", 32'(bus_req), 32'd0);

        // Randomized transactions, with stray acks while idle
        for (int n = 0; n < 200; n++) begin
            if (($urandom % 4) == 0) begin
                bus_ack = 1'b1; bus_rdata = $urandom;
                tick();
                bus_ack = 1'b0;
                chk($sformatf("rnd%0d idle ack out_valid", n), 32'(out_valid), 32'd0);
                chk($sformatf("rnd%0d idle ack bus_req", n), 32'(bus_req), 32'd0);
            end
            rv.ack_dly = $urandom_range(0, TMO);
            model(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom, rv);
            do_txn($sformatf("rnd%0d", n), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
